// File: rtl/control_sequencer_if.sv
// Control sequencer <-> datapath signal bundle.
// master: the sequencer (drives enables, reads IR/MemReady).
// slave:  the datapath side (drives IR/MemReady, reads enables).
interface control_sequencer_if;
   logic [31:0] IR;
   logic        MemReady;
   logic        PCout, Zlowout, MDRout, Rout;
   logic        MARin, Zin, PCin, MDRin, IRin, Yin, Rin;
   logic        IncPC, Read;
   logic        ADD, SUB, AND, OR;
   logic        Gra, Grb, Grc;
   logic        Run;
   logic [15:0] InstrCount;
   logic [3:0]  Tstate;

   modport master (
      input  IR, MemReady,
      output PCout, Zlowout, MDRout, Rout,
      output MARin, Zin, PCin, MDRin, IRin, Yin, Rin,
      output IncPC, Read, ADD, SUB, AND, OR, Gra, Grb, Grc,
      output Run, InstrCount, Tstate
   );

   modport slave (
      output IR, MemReady,
      input  PCout, Zlowout, MDRout, Rout,
      input  MARin, Zin, PCin, MDRin, IRin, Yin, Rin,
      input  IncPC, Read, ADD, SUB, AND, OR, Gra, Grb, Grc,
      input  Run, InstrCount, Tstate
   );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired control sequencer: fetch (T0-T2), decode (T3), ALU
// register-to-register execute (T4-T5), with memory wait and halt.
module control_sequencer (
   input  logic                Clock,
   input  logic                Reset,
   control_sequencer_if.master bus
);

   typedef enum logic [3:0] {
      S_RESET = 4'd0,
      S_T0    = 4'd1,
      S_T1    = 4'd2,
      S_T1W   = 4'd3,
      S_T2    = 4'd4,
      S_T3    = 4'd5,
      S_T4    = 4'd6,
      S_T5    = 4'd7,
      S_HALT  = 4'd8
   } state_t;

   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_SUB  = 5'b00100;
   localparam logic [4:0] OP_AND  = 5'b00101;
   localparam logic [4:0] OP_OR   = 5'b00110;
   localparam logic [4:0] OP_HALT = 5'b11011;

   state_t      r_state;
   logic [15:0] r_instr_cnt;
   logic [4:0]  r_op;

   logic [4:0]  w_opcode;
   logic        w_alu_op;
   logic        w_unused_ir;

   logic w_pcout, w_zlowout, w_mdrout, w_rout;
   logic w_marin, w_zin, w_pcin, w_mdrin, w_irin, w_yin, w_rin;
   logic w_incpc, w_read, w_add, w_sub, w_and, w_or;
   logic w_gra, w_grb, w_grc;

   assign w_opcode    = bus.IR[31:27];
   assign w_alu_op    = (w_opcode == OP_ADD) || (w_opcode == OP_SUB) ||
                        (w_opcode == OP_AND) || (w_opcode == OP_OR);
   // register fields are decoded by the datapath's select-encode logic
   assign w_unused_ir = ^bus.IR[26:0];

   // state sequencing, opcode latch for T4 and retired-instruction count
   always_ff @(posedge Clock) begin
      if (!Reset) begin
         r_state     <= S_RESET;
         r_instr_cnt <= '0;
         r_op        <= '0;
      end else begin
         case (r_state)
            S_RESET: r_state <= S_T0;
            S_T0:    r_state <= S_T1;
            S_T1:    r_state <= bus.MemReady ? S_T2 : S_T1W;
            S_T1W:   if (bus.MemReady) r_state <= S_T2;
            S_T2:    r_state <= S_T3;
            S_T3: begin
               r_op <= w_opcode;
               if (w_alu_op) begin
                  r_state <= S_T4;
               end else begin
                  r_instr_cnt <= r_instr_cnt + 16'd1;
                  r_state     <= (w_opcode == OP_HALT) ? S_HALT : S_T0;
               end
            end
            S_T4:    r_state <= S_T5;
            S_T5: begin
               r_instr_cnt <= r_instr_cnt + 16'd1;
               r_state     <= S_T0;
            end
            S_HALT:  r_state <= S_HALT;
            default: r_state <= S_RESET;
         endcase
      end
   end

   // control enables decoded from the state register; T3 must see the IR
   // loaded on the T2->T3 edge, so enables are decoded rather than registered
   always_comb begin
      w_pcout = 1'b0; w_zlowout = 1'b0; w_mdrout = 1'b0; w_rout = 1'b0;
      w_marin = 1'b0; w_zin = 1'b0; w_pcin = 1'b0; w_mdrin = 1'b0;
      w_irin = 1'b0; w_yin = 1'b0; w_rin = 1'b0;
      w_incpc = 1'b0; w_read = 1'b0;
      w_add = 1'b0; w_sub = 1'b0; w_and = 1'b0; w_or = 1'b0;
      w_gra = 1'b0; w_grb = 1'b0; w_grc = 1'b0;
      case (r_state)
         S_T0: begin
            w_pcout = 1'b1; w_marin = 1'b1; w_incpc = 1'b1; w_zin = 1'b1;
         end
         S_T1: begin
            w_zlowout = 1'b1; w_pcin = 1'b1; w_read = 1'b1; w_mdrin = 1'b1;
         end
         S_T1W: begin
            w_read = 1'b1; w_mdrin = 1'b1;
         end
         S_T2: begin
            w_mdrout = 1'b1; w_irin = 1'b1;
         end
         S_T3: begin
            if (w_alu_op) begin
               w_grb = 1'b1; w_rout = 1'b1; w_yin = 1'b1;
            end
         end
         S_T4: begin
            w_grc = 1'b1; w_rout = 1'b1; w_zin = 1'b1;
            w_add = (r_op == OP_ADD);
            w_sub = (r_op == OP_SUB);
            w_and = (r_op == OP_AND);
            w_or  = (r_op == OP_OR);
         end
         S_T5: begin
            w_zlowout = 1'b1; w_gra = 1'b1; w_rin = 1'b1;
         end
         default: ;
      endcase
   end

   assign bus.PCout      = w_pcout;
   assign bus.Zlowout    = w_zlowout;
   assign bus.MDRout     = w_mdrout;
   assign bus.Rout       = w_rout;
   assign bus.MARin      = w_marin;
   assign bus.Zin        = w_zin;
   assign bus.PCin       = w_pcin;
   assign bus.MDRin      = w_mdrin;
   assign bus.IRin       = w_irin;
   assign bus.Yin        = w_yin;
   assign bus.Rin        = w_rin;
   assign bus.IncPC      = w_incpc;
   assign bus.Read       = w_read;
   assign bus.ADD        = w_add;
   assign bus.SUB        = w_sub;
   assign bus.AND        = w_and;
   assign bus.OR         = w_or;
   assign bus.Gra        = w_gra;
   assign bus.Grb        = w_grb;
   assign bus.Grc        = w_grc;
   assign bus.Run        = (r_state != S_RESET) && (r_state != S_HALT);
   assign bus.InstrCount = r_instr_cnt;
   assign bus.Tstate     = r_state;

endmodule
